move_slot_scheduler: RTL and testbench

//  Game-phase controller and movement-slot scheduler for the sprite movers (pacman + ghosts).

---
 rtl/game_pkg.sv | 22 ++
 rtl/move_slot_scheduler_rr_pick.sv | 36 +++
 rtl/move_slot_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_move_slot_scheduler.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types for the game-phase controller and move-slot scheduler.
//   phase_t       : externally visible game phase (encoding is the phase port value)
//   sched_state_t : move-slot scheduler states
//   DEF_TICK_DIV  : default clk cycles per movement tick
package game_pkg;

  typedef enum logic [1:0] {
    PH_INI  = 2'd0,
    PH_PLAY = 2'd1,
    PH_WIN  = 2'd2,
    PH_LOSE = 2'd3
  } phase_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARB  = 2'd1,
    S_WAIT = 2'd2
  } sched_state_t;

  localparam int unsigned DEF_TICK_DIV = 500000;

endpackage

// File: rtl/move_slot_scheduler_rr_pick.sv
// Combinational round-robin picker.
//   pending : candidate request bits
//   ptr     : index of the most recently served bit
//   onehot  : first set pending bit strictly after ptr (wrapping), one-hot
//   idx     : index of that bit
//   valid   : at least one pending bit was set
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N-1:0]     pending,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     onehot,
  output logic [PTR_W-1:0] idx,
  output logic             valid
);

  logic [PTR_W-1:0] cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    cand   = '0;
    // Walk offsets 1..N so the search starts just after ptr and ends on ptr itself.
    for (int unsigned i = 1; i <= N; i++) begin
      cand = PTR_W'((32'(ptr) + i) % N);
      if (!valid && pending[cand]) begin
        onehot[cand] = 1'b1;
        idx          = cand;
        valid        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/move_slot_scheduler.sv
// Game-phase controller and movement-slot scheduler for the sprite movers.
// Divides clk into a movement tick while in PLAY and hands each requesting mover
// one exclusive move slot per tick, round-robin, via a req/grant/done handshake.
//   clk, reset_n : clock, asynchronous active-low reset
//   start/ack/win/lose : game FSM level inputs
//   req, done    : per-mover slot request (sampled at tick) and completion
//   grant        : registered one-hot (or zero) move permission
//   tick_pulse   : 1-cycle pulse every TICK_DIV cycles while in PLAY
//   phase        : INI=0, PLAY=1, WIN=2, LOSE=3
//   busy         : scheduler is arbitrating or waiting on a mover
//   overrun      : sticky, a tick arrived while busy
//   timeout_err  : sticky, a grant was revoked after TIMEOUT cycles
module move_slot_scheduler
  import game_pkg::*;
#(
  parameter int unsigned N_MOVERS = 4,
  parameter int unsigned TICK_DIV = DEF_TICK_DIV,
  parameter int unsigned CNT_W    = 20,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                ack,
  input  logic                win,
  input  logic                lose,
  input  logic [N_MOVERS-1:0] req,
  input  logic [N_MOVERS-1:0] done,
  output logic [N_MOVERS-1:0] grant,
  output logic                tick_pulse,
  output logic [1:0]          phase,
  output logic                busy,
  output logic                overrun,
  output logic                timeout_err
);

  localparam int unsigned PTR_W  = (N_MOVERS > 1) ? $clog2(N_MOVERS) : 1;
  localparam int unsigned WCNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT - 1);

  phase_t phase_q, phase_nxt;
  logic   stay_play;

  logic [CNT_W-1:0] div_cnt;

  sched_state_t        state_q, state_nxt;
  logic [N_MOVERS-1:0] pending_q, pending_nxt;
  logic [N_MOVERS-1:0] grant_nxt;
  logic [PTR_W-1:0]    ptr_q, ptr_nxt;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_nxt;
  logic                ovr_set, to_set;
  logic                slot_end;

  logic [N_MOVERS-1:0] pick_onehot;
  logic [PTR_W-1:0]    pick_idx;
  logic                pick_valid;

  rr_pick #(
    .N     (N_MOVERS),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .pending (pending_q),
    .ptr     (ptr_q),
    .onehot  (pick_onehot),
    .idx     (pick_idx),
    .valid   (pick_valid)
  );

  // ---------------- phase FSM ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) phase_q <= PH_INI;
    else          phase_q <= phase_nxt;
  end

  always_comb begin
    phase_nxt = phase_q;
    case (phase_q)
      PH_INI:  if (start) phase_nxt = PH_PLAY;
      PH_PLAY: begin
        if (win)       phase_nxt = PH_WIN;
        else if (lose) phase_nxt = PH_LOSE;
      end
      PH_WIN, PH_LOSE: if (ack) phase_nxt = PH_INI;
      default: phase_nxt = PH_INI;
    endcase
  end

  // Scheduler and divider only run while PLAY persists across this edge, so a
  // phase change kills any slot in the same edge that updates phase.
  assign stay_play = (phase_q == PH_PLAY) && (phase_nxt == PH_PLAY);
  assign phase     = phase_q;
  assign busy      = (state_q != S_IDLE);

  // ---------------- tick divider ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt    <= '0;
      tick_pulse <= 1'b0;
    end else if (stay_play) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt    <= '0;
        tick_pulse <= 1'b1;
      end else begin
        div_cnt    <= div_cnt + CNT_W'(1);
        tick_pulse <= 1'b0;
      end
    end else begin
      div_cnt    <= '0;
      tick_pulse <= 1'b0;
    end
  end

  // ---------------- scheduler FSM ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      grant     <= '0;
      ptr_q     <= PTR_W'(N_MOVERS - 1);
      wcnt_q    <= '0;
    end else begin
      state_q   <= state_nxt;
      pending_q <= pending_nxt;
      grant     <= grant_nxt;
      ptr_q     <= ptr_nxt;
      wcnt_q    <= wcnt_nxt;
    end
  end

  // Only the granted mover's done counts; the wait counter covers the timeout.
  assign slot_end = ((done & grant) != '0) || (wcnt_q == WAIT_LAST);

  always_comb begin
    state_nxt   = state_q;
    pending_nxt = pending_q;
    grant_nxt   = grant;
    ptr_nxt     = ptr_q;
    wcnt_nxt    = wcnt_q;
    ovr_set     = 1'b0;
    to_set      = 1'b0;
    if (!stay_play) begin
      state_nxt   = S_IDLE;
      pending_nxt = '0;
      grant_nxt   = '0;
      wcnt_nxt    = '0;
    end else begin
      if (tick_pulse && (state_q != S_IDLE)) ovr_set = 1'b1;
      case (state_q)
        S_IDLE: begin
          if (tick_pulse) begin
            pending_nxt = req;
            if (req != '0) state_nxt = S_ARB;
          end
        end
        S_ARB: begin
          if (pick_valid) begin
            grant_nxt = pick_onehot;
            ptr_nxt   = pick_idx;
            wcnt_nxt  = '0;
            state_nxt = S_WAIT;
          end else begin
            state_nxt = S_IDLE;
          end
        end
        S_WAIT: begin
          if (slot_end) begin
            to_set      = ((done & grant) == '0);
            grant_nxt   = '0;
            pending_nxt = pending_q & ~grant;
            wcnt_nxt    = '0;
            state_nxt   = ((pending_q & ~grant) != '0) ? S_ARB : S_IDLE;
          end else begin
            wcnt_nxt = wcnt_q + WCNT_W'(1);
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // ---------------- sticky flags ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else if (phase_nxt == PH_INI) begin
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (ovr_set) overrun     <= 1'b1;
      if (to_set)  timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_move_slot_scheduler.sv
module tb_move_slot_scheduler;

  localparam int N       = 4;
  localparam int TDIV    = 8;
  localparam int TIMEOUT = 6;

  logic       clk;
  logic       reset_n;
  logic       start, ack, win, lose;
  logic [3:0] req, done, grant;
  logic       tick_pulse, busy, overrun, timeout_err;
  logic [1:0] phase;

  move_slot_scheduler #(
    .N_MOVERS (N),
    .TICK_DIV (TDIV),
    .CNT_W    (4),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .ack         (ack),
    .win         (win),
    .lose        (lose),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .tick_pulse  (tick_pulse),
    .phase       (phase),
    .busy        (busy),
    .overrun     (overrun),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: values describe the current cycle.
  int m_phase;      // 0 INI, 1 PLAY, 2 WIN, 3 LOSE
  int m_pc;         // cycles elapsed since entering PLAY
  bit m_tick;
  int m_q[$];       // movers still to serve this tick, in service order
  int m_grant;      // -1 when no grant visible
  bit m_gap;        // arbitration cycle before the next grant
  int m_held;       // cycles the current grant has been visible
  int m_last;       // most recently served mover
  bit m_ovr, m_toe;

  // Stimulus control
  int         dly;
  logic [3:0] withhold;
  bit         rand_mode;
  logic [3:0] gseq[$];
  logic [3:0] prev_grant;
  int         g1cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_pc = 0; m_tick = 0; m_q.delete(); m_grant = -1;
    m_gap = 0; m_held = 0; m_last = N - 1; m_ovr = 0; m_toe = 0;
  endtask

  task automatic model_edge();
    int  np;
    bit  stay, bsy;
    int  j;
    np = m_phase;
    case (m_phase)
      0: if (start) np = 1;
      1: begin if (win) np = 2; else if (lose) np = 3; end
      default: if (ack) np = 0;
    endcase
    stay = (m_phase == 1) && (np == 1);
    if (!stay) begin
      m_q.delete(); m_grant = -1; m_gap = 0; m_held = 0;
    end else begin
      bsy = m_gap || (m_grant >= 0);
      if (m_tick && bsy) m_ovr = 1;
      if (m_gap) begin
        m_grant = m_q[0]; m_last = m_q[0]; m_gap = 0; m_held = 1;
      end else if (m_grant >= 0) begin
        if (done[m_grant[1:0]] || m_held == TIMEOUT) begin
          if (!done[m_grant[1:0]]) m_toe = 1;
          void'(m_q.pop_front());
          m_grant = -1;
          m_gap = (m_q.size() > 0);
        end else begin
          m_held++;
        end
      end else if (m_tick) begin
        for (int i = 1; i <= N; i++) begin
          j = (m_last + i) % N;
          if (req[j[1:0]]) m_q.push_back(j);
        end
        m_gap = (m_q.size() > 0);
      end
    end
    if (np == 0) begin m_ovr = 0; m_toe = 0; end
    m_tick = stay && (((m_pc + 1) % TDIV) == 0);
    m_pc = (np == 1 && m_phase == 1) ? m_pc + 1 : 0;
    m_phase = np;
  endtask

  task automatic check_all(input string tag);
    logic [3:0] eg;
    eg = (m_grant >= 0) ? (4'b0001 << m_grant) : 4'b0000;
    chk({tag, "_grant"}, 32'(grant), 32'(eg));
    chk({tag, "_tick"},  32'(tick_pulse), 32'(m_tick));
    chk({tag, "_phase"}, 32'(phase), 32'(m_phase));
    chk({tag, "_busy"},  32'(busy), 32'(m_gap || (m_grant >= 0)));
    chk({tag, "_ovr"},   32'(overrun), 32'(m_ovr));
    chk({tag, "_toe"},   32'(timeout_err), 32'(m_toe));
  endtask

  task automatic step();
    if (rand_mode) begin
      done = 4'($urandom);
    end else begin
      done = '0;
      if (m_grant >= 0 && !withhold[m_grant[1:0]] && m_held >= dly) done[m_grant[1:0]] = 1'b1;
    end
    @(posedge clk);
    model_edge();
    #1;
    check_all("cyc");
    if (grant != 4'b0000 && prev_grant == 4'b0000) gseq.push_back(grant);
    if (grant == 4'b0010) g1cnt++;
    prev_grant = grant;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_tick();
    for (int k = 0; k < 3 * TDIV && !m_tick; k++) step();
    if (!m_tick) begin
      n_vec++; n_err++;
      $error("FAIL tick_wait: observed no tick expected tick within %0d cycles", 3 * TDIV);
    end
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all({tag, "_async"});
    @(posedge clk);
    #1;
    check_all({tag, "_held"});
    @(negedge clk);
    reset_n = 1'b1;
    prev_grant = 4'b0000;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; start = 0; ack = 0; win = 0; lose = 0; req = '0; done = '0;
    dly = 1; withhold = '0; rand_mode = 0; prev_grant = '0; g1cnt = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    reset_n = 1'b1;

    // Three movers served in order with one-cycle completion.
    start = 1; step(); start = 0;
    req = 4'b1011; dly = 1; gseq.delete();
    wait_tick(); step(); run(6);
    chk("seqA_len", 32'(gseq.size()), 32'd3);
    chk("seqA_0", 32'((gseq.size() > 0) ? gseq[0] : 4'h0), 32'h1);
    chk("seqA_1", 32'((gseq.size() > 1) ? gseq[1] : 4'h0), 32'h2);
    chk("seqA_2", 32'((gseq.size() > 2) ? gseq[2] : 4'h0), 32'h8);

    // Wrap order from pointer=3.
    req = 4'b1001; gseq.delete();
    wait_tick(); step(); run(4);
    chk("seqB_len", 32'(gseq.size()), 32'd2);
    chk("seqB_0", 32'((gseq.size() > 0) ? gseq[0] : 4'h0), 32'h1);
    chk("seqB_1", 32'((gseq.size() > 1) ? gseq[1] : 4'h0), 32'h8);

    // Mover 1 never completes.
    req = 4'b0010; withhold = 4'b0010; g1cnt = 0;
    wait_tick(); step(); run(7);
    chk("timeout_hold", 32'(g1cnt), 32'd6);
    chk("timeout_flag", 32'(timeout_err), 32'd1);
    withhold = '0;

    // win and lose together mid-slot, then ack.
    req = 4'b0001; dly = 100;
    wait_tick(); step(); step(); step();
    win = 1; lose = 1; step(); win = 0; lose = 0;
    chk("win_phase", 32'(phase), 32'd2);
    chk("win_grant", 32'(grant), 32'd0);
    ack = 1; step(); ack = 0;
    chk("ini_phase", 32'(phase), 32'd0);
    chk("ini_flags", 32'({overrun, timeout_err}), 32'd0);

    // Slots outlast the tick period.
    start = 1; step(); start = 0;
    req = 4'b1111; withhold = 4'b1111;
    wait_tick(); step(); run(12);
    chk("overrun_flag", 32'(overrun), 32'd1);

    // Reset while a grant is visible.
    for (int k = 0; k < 20 && m_grant < 0; k++) step();
    chk("pre_rst_grant", 32'(grant != 4'b0000), 32'd1);
    do_reset("midrst");
    withhold = '0; req = '0; dly = 1;
    step();
    chk("post_rst_phase", 32'(phase), 32'd0);

    // Randomised traffic.
    rand_mode = 1;
    for (int i = 0; i < 2000; i++) begin
      start = ($urandom_range(0, 7) == 0);
      win   = ($urandom_range(0, 79) == 0);
      lose  = ($urandom_range(0, 79) == 0);
      ack   = ($urandom_range(0, 3) == 0);
      req   = 4'($urandom);
      if ($urandom_range(0, 699) == 0) do_reset("rndrst");
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
